fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  - IF stage of the RISC-V pipeline: owns the PC register, drives pc_o to the
//    combinational instruction_memory, and registers {pc, pc+4, inst} into IF/ID.
//  - Handles stall from the hazard unit, redirects from EX (branch/jump), halt,
//    and two sticky faults: misaligned redirect target and fetch beyond IMEM depth.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  IMEM_WORDS 51             instruction memory depth in 32-bit words; fetch limit = IMEM_WORDS*4
//  NOP_INST   32'h0000_0013  bubble instruction (addi x0,x0,0)
// PORTS
//  clk               in   1   clock; all state updates on rising edge
//  rst               in   1   asynchronous, active-high reset
//  stall_i           in   1   hazard unit: hold PC and IF/ID
//  redirect_i        in   1   EX: taken branch/jump; overrides stall_i
//  redirect_pc_i     in   32  redirect target
//  halt_i            in   1   enter HALT (ecall/ebreak retired)
//  inst_i            in   32  instruction from instruction_memory (same-cycle read of pc_o)
//  pc_o              out  32  fetch address to instruction_memory (= pc_q)
//  if_id_valid_o     out  1   IF/ID holds a real instruction
//  if_id_pc_o        out  32  PC of IF/ID instruction
//  if_id_pc_plus4_o  out  32  PC+4 of IF/ID instruction
//  if_id_inst_o      out  32  IF/ID instruction (NOP_INST when invalid)
//  misalign_o        out  1   sticky: redirect target with [1:0]!=0
//  fault_o           out  1   sticky: fetch address >= IMEM_WORDS*4
//  halted_o          out  1   state == HALT
// BEHAVIOUR
//  - Reset (async assert, async effect): pc_q=RESET_PC, state=BOOT, if_id_valid_o=0,
//    if_id_pc_o=0, if_id_pc_plus4_o=0, if_id_inst_o=NOP_INST, misalign_o=0, fault_o=0, halted_o=0.
//  - FSM: BOOT -> RUN unconditionally after 1 cycle (PC held, IF/ID bubble).
//    RUN -> HALT on halt_i, misaligned redirect, or fetch fault. HALT is terminal until rst.
//  - Bubble = {valid=0, pc=0, pc+4=0, inst=NOP_INST}.
//  - RUN, per-edge priority (highest first):
//    1 halt_i: IF/ID<=bubble, pc_q held, ->HALT.
//    2 redirect_i & redirect_pc_i[1:0]!=0: misalign_o<=1, IF/ID<=bubble, pc_q held, ->HALT.
//    3 redirect_i: pc_q<=redirect_pc_i, IF/ID<=bubble (flush wrong-path inst); stall_i ignored.
//    4 stall_i: pc_q and IF/ID hold all values.
//    5 pc_q >= IMEM_WORDS*4: fault_o<=1, IF/ID<=bubble, ->HALT; inst_i not captured.
//    6 else: IF/ID<={1, pc_q, pc_q+4, inst_i}; pc_q<=pc_q+4.
//  - pc+4 is 32-bit modulo (wraps 32'hFFFF_FFFC -> 0); limit check via rule 5.
//  - Redirect latency: target appears on pc_o the cycle after redirect_i; its inst is
//    in IF/ID one cycle later (1 bubble per taken redirect).
//  - Sequential fetch latency: inst at pc_o in cycle N is on if_id_*_o in cycle N+1.
//  - HALT: pc_q held, IF/ID bubble, all inputs ignored, sticky flags held.
//  - Reset mid-operation: immediate return to reset values; no partial IF/ID update.
//  - halted_o is combinational from state.
// STRUCTURE
//  - rv_pipe_pkg: fetch_state_e {FS_BOOT, FS_RUN, FS_HALT}; if_id_t struct
//    {valid, pc, pc_plus4, inst}; localparam NOP_INST; function if_id_bubble().
//  - One sub-module: if_id_reg (if_id_t register with hold/load/flush inputs,
//    async active-high reset to bubble); PC register, next-PC mux, FSM in fetch_stage.
// TESTING
//  - Reset/boot: rst 3 cycles, release -> pc_o=0 for 2 cycles (BOOT+first RUN),
//    valid=0 during BOOT; cycle after first RUN edge if_id_pc_o=0, inst=mem[0].
//  - Straight-line: 5 RUN cycles -> if_id_pc_o 0,4,8,12,16; pc_plus4 = pc+4; inst=mem[pc>>2].
//  - Stall: stall_i high 3 cycles at pc_o=8 -> pc_o and all if_id_*_o frozen; resume with pc_o=12.
//  - Redirect vs stall: redirect_i=1, stall_i=1, target 32'h20 -> next pc_o=32'h20, valid=0;
//    following cycle if_id_pc_o=32'h20.
//  - Misalign: redirect_pc_i=32'h22 -> misalign_o=1, halted_o=1, pc_o unchanged, valid=0 forever.
//  - Fetch limit: IMEM_WORDS=4, run from 0 -> PCs 0..12 captured, at pc_o=16 fault_o=1,
//    halted_o=1, no capture; later halt_i/redirect_i have no effect; rst clears fault_o.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared types for the fetch stage: FSM states, the IF/ID pipeline entry,
// and the bubble constructor used on flush and reset.
package rv_pipe_pkg;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] inst;
    } if_id_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic if_id_t if_id_bubble(input logic [31:0] nop_inst);
        if_id_t b;
        b.valid    = 1'b0;
        b.pc       = 32'h0000_0000;
        b.pc_plus4 = 32'h0000_0000;
        b.inst     = nop_inst;
        return b;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise the entry holds.
// Reset drops a bubble into the register.
module if_id_reg #(
    parameter logic [31:0] NOP_INST = rv_pipe_pkg::NOP_INST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               flush_i,
    input  rv_pipe_pkg::if_id_t d_i,
    output rv_pipe_pkg::if_id_t q_o
);
    import rv_pipe_pkg::*;

    if_id_t entry_d;
    if_id_t entry_q;

    // Next entry selection: flush, load, or hold
    always_comb begin
        entry_d = entry_q;
        if (flush_i) begin
            entry_d = if_id_bubble(NOP_INST);
        end else if (load_i) begin
            entry_d = d_i;
        end else begin
            entry_d = entry_q;
        end
    end

    // Entry storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= if_id_bubble(NOP_INST);
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection and BOOT/RUN/HALT control,
// feeding the IF/ID register with sticky misalign and fetch-limit faults.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 51,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    input  logic [31:0] inst_i,
    output logic [31:0] pc_o,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc_plus4_o,
    output logic [31:0] if_id_inst_o,
    output logic        misalign_o,
    output logic        fault_o,
    output logic        halted_o
);
    import rv_pipe_pkg::*;

    localparam logic [31:0] FETCH_LIMIT = 32'(IMEM_WORDS) * 32'd4;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         misalign_q, misalign_d;
    logic         fault_q, fault_d;
    logic         ifid_load_s, ifid_flush_s;
    if_id_t       ifid_d_s, ifid_q_s;
    logic [31:0]  pc_plus4_s;
    logic         redirect_misaligned_s;
    logic         limit_hit_s;

    assign pc_plus4_s            = pc_q + 32'd4;
    assign redirect_misaligned_s = (redirect_pc_i[1:0] != 2'b00);
    assign limit_hit_s           = (pc_q >= FETCH_LIMIT);

    // State, PC and sticky fault registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FS_BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
        end
    end

    // Next-state logic; a stalled or redirected cycle never checks the fetch limit
    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_BOOT: state_d = FS_RUN;
            FS_RUN: begin
                if (halt_i || (redirect_i && redirect_misaligned_s) ||
                    (!redirect_i && !stall_i && limit_hit_s)) begin
                    state_d = FS_HALT;
                end else begin
                    state_d = FS_RUN;
                end
            end
            FS_HALT: state_d = FS_HALT;
            default: state_d = FS_HALT;
        endcase
    end

    // Datapath control: next PC, IF/ID load/flush and sticky flags
    always_comb begin
        pc_d         = pc_q;
        misalign_d   = misalign_q;
        fault_d      = fault_q;
        ifid_load_s  = 1'b0;
        ifid_flush_s = 1'b0;
        ifid_d_s.valid    = 1'b1;
        ifid_d_s.pc       = pc_q;
        ifid_d_s.pc_plus4 = pc_plus4_s;
        ifid_d_s.inst     = inst_i;
        case (state_q)
            FS_RUN: begin
                if (halt_i) begin
                    ifid_flush_s = 1'b1;
                end else if (redirect_i && redirect_misaligned_s) begin
                    misalign_d   = 1'b1;
                    ifid_flush_s = 1'b1;
                end else if (redirect_i) begin
                    pc_d         = redirect_pc_i;
                    ifid_flush_s = 1'b1;
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else if (limit_hit_s) begin
                    fault_d      = 1'b1;
                    ifid_flush_s = 1'b1;
                end else begin
                    ifid_load_s = 1'b1;
                    pc_d        = pc_plus4_s;
                end
            end
            FS_BOOT: ifid_flush_s = 1'b1;
            FS_HALT: ifid_flush_s = 1'b1;
            default: ifid_flush_s = 1'b1;
        endcase
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ifid_load_s),
        .flush_i (ifid_flush_s),
        .d_i     (ifid_d_s),
        .q_o     (ifid_q_s)
    );

    assign pc_o             = pc_q;
    assign if_id_valid_o    = ifid_q_s.valid;
    assign if_id_pc_o       = ifid_q_s.pc;
    assign if_id_pc_plus4_o = ifid_q_s.pc_plus4;
    assign if_id_inst_o     = ifid_q_s.inst;
    assign misalign_o       = misalign_q;
    assign fault_o          = fault_q;
    assign halted_o         = (state_q == FS_HALT);

endmodule
